// File: rtl/rx_dsp_arbiter.sv
// Packet-aware round-robin arbiter merging NUM_INPUTS fifo36 streams into one.
// A grant is held from SOF through EOF and may carry up to 'quota' packets.
module rx_dsp_arbiter #(
  parameter int NUM_INPUTS = 2,
  parameter int BASE       = 12
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     set_stb,
  input  logic [7:0]               set_addr,
  input  logic [31:0]              set_data,
  input  logic [36*NUM_INPUTS-1:0] data_i,
  input  logic [NUM_INPUTS-1:0]    src_rdy_i,
  output logic [NUM_INPUTS-1:0]    dst_rdy_o,
  output logic [35:0]              data_o,
  output logic                     src_rdy_o,
  input  logic                     dst_rdy_i,
  output logic [2:0]               active_port,
  output logic                     busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_HOLD} state_t;

  state_t                  state_reg, state_next;
  logic [NUM_INPUTS-1:0]   mask_reg;
  logic [7:0]              quota_reg;
  logic [7:0]              quota_act_reg, quota_act_next;
  logic [2:0]              sel_reg, sel_next;
  logic [2:0]              ptr_reg, ptr_next;
  logic [7:0]              pkt_cnt_reg, pkt_cnt_next;

  // Inputs padded out to eight lanes so a 3-bit select can index them directly.
  logic [35:0]             data_arr [8];
  logic [7:0]              src_pad;
  logic [7:0]              en_pad;
  logic [7:0]              req;
  logic                    found;
  logic [2:0]              cand;
  logic                    xfer_eof;
  logic                    unused_set_bits;

  for (genvar gi = 0; gi < 8; gi++) begin : g_pad
    if (gi < NUM_INPUTS) begin : g_on
      assign data_arr[gi] = data_i[36*gi +: 36];
      assign src_pad[gi]  = src_rdy_i[gi];
      assign en_pad[gi]   = mask_reg[gi];
    end else begin : g_off
      assign data_arr[gi] = '0;
      assign src_pad[gi]  = 1'b0;
      assign en_pad[gi]   = 1'b0;
    end
  end

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_dst
    assign dst_rdy_o[gi] = (state_reg == ST_PASS) && (sel_reg == 3'(gi)) && dst_rdy_i;
  end

  assign req             = src_pad & en_pad;
  assign active_port     = sel_reg;
  assign busy            = (state_reg != ST_IDLE);
  assign unused_set_bits = ^set_data[31:8];

  // Settings survive 'clear'; only reset_n restores them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_reg  <= '1;
      quota_reg <= 8'd1;
    end else if (set_stb) begin
      if (set_addr == 8'(BASE))
        mask_reg <= set_data[NUM_INPUTS-1:0];
      if (set_addr == 8'(BASE + 1))
        quota_reg <= (set_data[7:0] == 8'd0) ? 8'd1 : set_data[7:0];
    end
  end

  // Round-robin scan starting just after the last granted input.
  always_comb begin
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_INPUTS; k++) begin
      if (!found && req[3'((int'(ptr_reg) + k) % NUM_INPUTS)]) begin
        found = 1'b1;
        cand  = 3'((int'(ptr_reg) + k) % NUM_INPUTS);
      end
    end
  end

  assign xfer_eof = src_pad[sel_reg] && dst_rdy_i && data_arr[sel_reg][33];

  always_comb begin
    state_next     = state_reg;
    sel_next       = sel_reg;
    ptr_next       = ptr_reg;
    pkt_cnt_next   = pkt_cnt_reg;
    quota_act_next = quota_act_reg;
    data_o         = '0;
    src_rdy_o      = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (found) begin
          sel_next       = cand;
          pkt_cnt_next   = 8'd0;
          quota_act_next = quota_reg;
          state_next     = ST_PASS;
        end
      end
      ST_PASS: begin
        data_o    = data_arr[sel_reg];
        src_rdy_o = src_pad[sel_reg];
        if (xfer_eof) begin
          pkt_cnt_next = pkt_cnt_reg + 8'd1;
          if ({1'b0, pkt_cnt_reg} + 9'd1 >= {1'b0, quota_act_reg}) begin
            ptr_next   = sel_reg;
            state_next = ST_IDLE;
          end else begin
            state_next = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // Quota is re-sampled here so a host update lands between packets.
        if (req[sel_reg]) begin
          quota_act_next = quota_reg;
          state_next     = ST_PASS;
        end else begin
          ptr_next   = sel_reg;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      sel_reg       <= '0;
      ptr_reg       <= 3'(NUM_INPUTS - 1);
      pkt_cnt_reg   <= '0;
      quota_act_reg <= 8'd1;
    end else if (clear) begin
      state_reg     <= ST_IDLE;
      sel_reg       <= '0;
      ptr_reg       <= 3'(NUM_INPUTS - 1);
      pkt_cnt_reg   <= '0;
      quota_act_reg <= 8'd1;
    end else begin
      state_reg     <= state_next;
      sel_reg       <= sel_next;
      ptr_reg       <= ptr_next;
      pkt_cnt_reg   <= pkt_cnt_next;
      quota_act_reg <= quota_act_next;
    end
  end

endmodule

// File: tb/tb_rx_dsp_arbiter.sv
// Scoreboard bench for rx_dsp_arbiter: a packet-level round-robin model fills
// the expected queue, and an output monitor pops and compares every word.
module tb_rx_dsp_arbiter;

  localparam int N    = 3;
  localparam int BASE = 12;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            clear = 1'b0;
  logic            set_stb = 1'b0;
  logic [7:0]      set_addr = '0;
  logic [31:0]     set_data = '0;
  logic [36*N-1:0] data_i = '0;
  logic [N-1:0]    src_rdy_i = '0;
  logic [N-1:0]    dst_rdy_o;
  logic [35:0]     data_o;
  logic            src_rdy_o;
  logic            dst_rdy_i = 1'b1;
  logic [2:0]      active_port;
  logic            busy;

  rx_dsp_arbiter #(.NUM_INPUTS(N), .BASE(BASE)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .data_i(data_i), .src_rdy_i(src_rdy_i), .dst_rdy_o(dst_rdy_o),
    .data_o(data_o), .src_rdy_o(src_rdy_o), .dst_rdy_i(dst_rdy_i),
    .active_port(active_port), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [35:0] word;
    int          port;
    int          gap;   // rising edges since the previous EOF transfer; 0 = unchecked
  } exp_t;

  exp_t        exp_q[$];
  logic [35:0] src_q [N][$];
  int          exp_left [N];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          words_seen = 0;
  int          cyc = 0;
  int          last_eof = 0;
  bit          mark_start = 1'b0;
  bit          thr = 1'b0;
  logic [N-1:0] acc = '0;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Output monitor: samples mid-cycle, after the inputs have settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      cyc++;
      if (mark_start) begin
        last_eof   = cyc - 1;
        mark_start = 1'b0;
      end
      if (reset_n && src_rdy_o && dst_rdy_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got %09h required none", data_o);
        end else begin
          e = exp_q.pop_front();
          check("data", data_o, e.word);
          check("active_port", active_port, e.port);
          check("busy", busy, 1);
          if (e.gap != 0) check("packet_gap", cyc - last_eof, e.gap);
          $display("t=%0t out port=%0d word=%09h", $time, active_port, data_o);
        end
        if (data_o[33]) last_eof = cyc;
        words_seen++;
      end
    end
  end

  // One clock of source behaviour: retire accepted words, present the next ones.
  // SOF words are never throttled so every loaded input requests at arbitration.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < N; i++)
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    dst_rdy_i = thr ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        data_i[36*i +: 36] = src_q[i][0];
        src_rdy_i[i] = src_q[i][0][32] || !thr || ($urandom_range(0, 1) == 1);
      end else begin
        data_i[36*i +: 36] = '0;
        src_rdy_i[i] = 1'b0;
      end
    end
    #2;
    acc = src_rdy_i & dst_rdy_o;
  endtask

  task automatic wr_reg(int addr, logic [31:0] val);
    tick();
    set_stb  = 1'b1;
    set_addr = 8'(addr);
    set_data = val;
    tick();
    set_stb  = 1'b0;
  endtask

  task automatic do_clear();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic load(int i, int npk, int len);
    int l;
    for (int p = 0; p < npk; p++) begin
      l = (len > 0) ? len : int'($urandom_range(1, 4));
      for (int w = 0; w < l; w++)
        src_q[i].push_back({2'($urandom_range(0, 3)), (w == l - 1), (w == 0),
                            8'(i), 8'(p), 8'(w), 8'($urandom)});
    end
  endtask

  // Packet-level reference: round robin over loaded, enabled inputs; each grant
  // takes up to 'quota' back-to-back packets from one input.
  task automatic build_model(int q, logic [2:0] m0, logic [2:0] m1, int chg,
                             int first_gap, bit throttle);
    logic [35:0] mq [N][$];
    logic [35:0] w;
    logic [2:0]  m;
    int ptr, emitted, nxt_gap, qq, g, cnt, j;
    bit first;
    for (int i = 0; i < N; i++) mq[i] = src_q[i];
    m = m0;
    ptr = N - 1;
    emitted = 0;
    nxt_gap = first_gap;
    qq = (q == 0) ? 1 : q;
    while (1) begin
      g = -1;
      for (int k = 1; k <= N; k++) begin
        j = (ptr + k) % N;
        if (g < 0 && mq[j].size() > 0 && m[j]) g = j;
      end
      if (g < 0) break;
      cnt = 0;
      do begin
        first = 1'b1;
        do begin
          w = mq[g].pop_front();
          exp_q.push_back('{word: w, port: g, gap: (first && !throttle) ? nxt_gap : 0});
          first = 1'b0;
        end while (!w[33]);
        emitted++;
        cnt++;
        if (emitted == chg) m = m1;
        nxt_gap = 2;
      end while (cnt < qq && mq[g].size() > 0 && m[g]);
      if (cnt < qq) nxt_gap = 3;
      ptr = g;
    end
    for (int i = 0; i < N; i++) exp_left[i] = mq[i].size();
  endtask

  task automatic run(string name, int n0, int n1, int n2, int len, int q,
                     logic [2:0] m, bit wr, bit throttle, int chg,
                     logic [2:0] m1, bit from_reset);
    int base, cnt;
    bit wrote;
    $display("scenario %s", name);
    if (!from_reset) begin
      if (wr) begin
        wr_reg(BASE, 32'(m));
        wr_reg(BASE + 1, 32'(q));
      end
      do_clear();
    end
    load(0, n0, len);
    load(1, n1, len);
    load(2, n2, len);
    build_model(q, m, m1, chg, from_reset ? 2 : 0, throttle);
    thr = throttle;
    if (from_reset) begin
      tick();
      check("rst_src_rdy_o", src_rdy_o, 0);
      check("rst_dst_rdy_o", dst_rdy_o, 0);
      check("rst_data_o", data_o, 0);
      check("rst_active_port", active_port, 0);
      check("rst_busy", busy, 0);
      reset_n    = 1'b1;
      mark_start = 1'b1;
    end
    base  = words_seen;
    wrote = 1'b0;
    cnt   = 0;
    while (exp_q.size() > 0 && cnt < 3000) begin
      tick();
      cnt++;
      set_stb = 1'b0;
      if (chg > 0 && !wrote && words_seen - base >= 1) begin
        set_stb  = 1'b1;
        set_addr = 8'(BASE);
        set_data = 32'(m1);
        wrote    = 1'b1;
      end
    end
    set_stb = 1'b0;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: %0d words outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (6) tick();
    for (int i = 0; i < N; i++)
      check($sformatf("%s_left%0d", name, i), src_q[i].size(), exp_left[i]);
    check($sformatf("%s_idle", name), busy, 0);
    for (int i = 0; i < N; i++) src_q[i].delete();
    thr = 1'b0;
  endtask

  initial begin
    int base, cnt;
    repeat (3) tick();
    run("rr_q1",       3, 3, 0, 4, 1, 3'b111, 1'b0, 1'b0, 0, 3'b111, 1'b1);
    run("quota3",      3, 3, 0, 4, 3, 3'b111, 1'b1, 1'b0, 0, 3'b111, 1'b0);
    run("quota3_short",1, 2, 0, 4, 3, 3'b111, 1'b1, 1'b0, 0, 3'b111, 1'b0);
    run("mask_mid",    3, 3, 0, 4, 1, 3'b011, 1'b1, 1'b0, 1, 3'b010, 1'b0);
    run("throttle_a",  4, 3, 5, 0, 2, 3'b111, 1'b1, 1'b1, 0, 3'b111, 1'b0);
    run("quota0_wrap", 2, 2, 2, 0, 0, 3'b111, 1'b1, 1'b0, 0, 3'b111, 1'b0);
    run("throttle_b",  3, 4, 3, 0, 3, 3'b101, 1'b1, 1'b1, 0, 3'b101, 1'b0);

    // Clear in the middle of input 1's third packet, after ptr has moved to 1.
    $display("scenario clear_mid");
    wr_reg(BASE, 32'(3'b110));
    wr_reg(BASE + 1, 32'd2);
    do_clear();
    load(1, 3, 4);
    build_model(2, 3'b110, 3'b110, 0, 0, 1'b0);
    base = words_seen;
    cnt  = 0;
    while (words_seen - base < 10 && cnt < 200) begin
      tick();
      cnt++;
    end
    check("clear_reach_mid", words_seen - base, 10);
    clear = 1'b1;
    tick();
    check("clear_busy", busy, 0);
    check("clear_dst_rdy_o", dst_rdy_o, 0);
    check("clear_src_rdy_o", src_rdy_o, 0);
    check("clear_active_port", active_port, 0);
    for (int i = 0; i < N; i++) src_q[i].delete();
    src_rdy_i = '0;
    clear = 1'b0;
    exp_q.delete();
    repeat (3) tick();

    // Settings untouched: mask 110 and quota 2 must have survived, ptr restarted.
    run("kept",        2, 2, 2, 0, 2, 3'b110, 1'b0, 1'b0, 0, 3'b110, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
